// File: rtl/cosim_trace_pkg.sv
// Shared types for the retire-side co-simulation trace queue.
// COSIM_TRAP_TRACE_EN adds the trap kind/cause fields to each stored record.
package cosim_trace_pkg;

    localparam int WADDR_W = 6;
    localparam int SEQ_W   = 64;

    typedef enum logic {
        COMMIT = 1'b0,
        TRAP   = 1'b1
    } trace_kind_e;

    typedef struct packed {
`ifdef COSIM_TRAP_TRACE_EN
        trace_kind_e         kind;
        logic [63:0]         cause;
`endif
        logic [63:0]         pc;
        logic [31:0]         insn;
        logic                wen;
        logic [WADDR_W-1:0]  waddr;
        logic [63:0]         wdata;
        logic [SEQ_W-1:0]    seq;
    } trace_entry_t;

endpackage

// File: rtl/commit_lane_compactor.sv
// Packs valid commit lanes (and the trap record under COSIM_TRAP_TRACE_EN) into
// consecutive slots in program order; slot.seq carries the offset from the base seq.
module commit_lane_compactor
    import cosim_trace_pkg::*;
#(
    parameter  int COMMITS = 2,
    localparam int SLOTS   = COMMITS + 1,
    localparam int CNT_W   = $clog2(COMMITS + 2)
) (
    input  logic [COMMITS-1:0]         commit_valid,
    input  logic [64*COMMITS-1:0]      commit_pc,
    input  logic [32*COMMITS-1:0]      commit_insn,
    input  logic [COMMITS-1:0]         commit_wen,
    input  logic [WADDR_W*COMMITS-1:0] commit_waddr,
    input  logic [64*COMMITS-1:0]      commit_wdata,
    input  logic                       trap_valid,
    input  logic [63:0]                trap_cause,
    output trace_entry_t               slot [SLOTS],
    output logic [CNT_W-1:0]           count,
    output logic [CNT_W-1:0]           commit_count
);

    logic [CNT_W-1:0] n;

    // NOTE: every output gets a default before the loop so no path leaves a value
    // held, which would infer a latch; blocking '=' lets n act as a running index.
    always_comb begin
        slot = '{default: '0};
        n    = '0;
        for (int i = 0; i < COMMITS; i++) begin
            if (commit_valid[i]) begin
`ifdef COSIM_TRAP_TRACE_EN
                slot[n].kind  = COMMIT;
`endif
                slot[n].pc    = commit_pc[i*64 +: 64];
                slot[n].insn  = commit_insn[i*32 +: 32];
                slot[n].wen   = commit_wen[i];
                slot[n].waddr = commit_waddr[i*WADDR_W +: WADDR_W];
                slot[n].wdata = commit_wdata[i*64 +: 64];
                slot[n].seq   = SEQ_W'(n);
                n             = n + CNT_W'(1);
            end
        end
        commit_count = n;
`ifdef COSIM_TRAP_TRACE_EN
        // A trap is younger than every lane and names the next unretired instruction.
        if (trap_valid) begin
            slot[n].kind  = TRAP;
            slot[n].cause = trap_cause;
            slot[n].seq   = SEQ_W'(n);
            n             = n + CNT_W'(1);
        end
`endif
        count = n;
    end

`ifndef COSIM_TRAP_TRACE_EN
    logic unused_trap;
    assign unused_trap = ^{trap_valid, trap_cause};
`endif

endmodule

// File: rtl/commit_trace_queue.sv
// Multi-lane retire trace FIFO with one-record-per-cycle FWFT drain to the checker.
// Trap capture is compiled in only when COSIM_TRAP_TRACE_EN is defined.
module commit_trace_queue
    import cosim_trace_pkg::*;
#(
    parameter  int COMMITS = 2,
    parameter  int DEPTH   = 16,
    parameter  int HARTID  = 0,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int OCC_W   = PTR_W + 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [COMMITS-1:0]         commit_valid,
    input  logic [64*COMMITS-1:0]      commit_pc,
    input  logic [32*COMMITS-1:0]      commit_insn,
    input  logic [COMMITS-1:0]         commit_wen,
    input  logic [WADDR_W*COMMITS-1:0] commit_waddr,
    input  logic [64*COMMITS-1:0]      commit_wdata,
    input  logic                       trap_valid,
    input  logic [63:0]                trap_cause,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_kind,
    output logic [63:0]                out_pc,
    output logic [31:0]                out_insn,
    output logic                       out_wen,
    output logic [WADDR_W-1:0]         out_waddr,
    output logic [63:0]                out_wdata,
    output logic [63:0]                out_cause,
    output logic [SEQ_W-1:0]           out_seq,
    output logic [31:0]                out_hartid,
    output logic                       overflow,
    output logic [OCC_W-1:0]           occupancy
);

    localparam int SLOTS = COMMITS + 1;
    localparam int CNT_W = $clog2(COMMITS + 2);

    trace_entry_t     slot     [SLOTS];
    trace_entry_t     wr_entry [SLOTS];
    trace_entry_t     mem      [DEPTH];
    trace_entry_t     head_entry;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] commit_count;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [SEQ_W-1:0] seq;
    logic [OCC_W-1:0] free_cnt;
    logic             accept;
    logic             deq;

    commit_lane_compactor #(.COMMITS(COMMITS)) u_compactor (
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_insn  (commit_insn),
        .commit_wen   (commit_wen),
        .commit_waddr (commit_waddr),
        .commit_wdata (commit_wdata),
        .trap_valid   (trap_valid),
        .trap_cause   (trap_cause),
        .slot         (slot),
        .count        (count),
        .commit_count (commit_count)
    );

    // Free space uses the pre-edge count only, so a same-cycle pop never makes room.
    assign free_cnt = OCC_W'(DEPTH) - occupancy;
    assign accept   = OCC_W'(count) <= free_cnt;
    assign out_valid = occupancy != '0;
    assign deq       = out_valid && out_ready;

    always_comb begin
        for (int s = 0; s < SLOTS; s++) begin
            wr_entry[s]     = slot[s];
            wr_entry[s].seq = seq + slot[s].seq;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            seq       <= '0;
            occupancy <= '0;
            overflow  <= 1'b0;
        end else begin
            if (accept) begin
                tail <= tail + PTR_W'(count);
                seq  <= seq + SEQ_W'(commit_count);
            end else begin
                overflow <= 1'b1;
            end
            if (deq) begin
                head <= head + PTR_W'(1);
            end
            occupancy <= occupancy + (accept ? OCC_W'(count) : '0) - OCC_W'(deq);
        end
    end

    // NOTE: the storage array has no reset; stale entries are never observable
    // because every output field is gated by out_valid, which comes from occupancy.
    always_ff @(posedge clock) begin
        if (accept) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (CNT_W'(s) < count) begin
                    mem[tail + PTR_W'(s)] <= wr_entry[s];
                end
            end
        end
    end

    assign head_entry = mem[head];
    assign out_pc     = out_valid ? head_entry.pc    : '0;
    assign out_insn   = out_valid ? head_entry.insn  : '0;
    assign out_wen    = out_valid ? head_entry.wen   : 1'b0;
    assign out_waddr  = out_valid ? head_entry.waddr : '0;
    assign out_wdata  = out_valid ? head_entry.wdata : '0;
    assign out_seq    = out_valid ? head_entry.seq   : '0;
    assign out_hartid = 32'(HARTID);

`ifdef COSIM_TRAP_TRACE_EN
    assign out_kind  = out_valid ? head_entry.kind  : 1'b0;
    assign out_cause = out_valid ? head_entry.cause : '0;
`else
    assign out_kind  = 1'b0;
    assign out_cause = '0;
`endif

endmodule
